// File: rtl/gray_pkg.sv
// gray_pkg: shared types and helpers for the Gray-code counter slice.
//
// Contents:
//   GRAY_MAX_W  - widest counter the helpers handle (32 bits)
//   conv_dir_e  - conversion direction selector for gray_conv
//   bin2gray()  - binary to reflected Gray, masked to a runtime width
//   gray2bin()  - reflected Gray to binary, masked to a runtime width
//   popcount()  - number of set bits within a runtime width
//
// The helpers work on a fixed 32-bit container and mask to the requested
// width, so one definition serves every counter width up to GRAY_MAX_W.
package gray_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  typedef enum logic {
    ConvBin2Gray = 1'b0,
    ConvGray2Bin = 1'b1
  } conv_dir_e;

  // Mask with the low w bits set; w >= GRAY_MAX_W yields all ones.
  function automatic logic [GRAY_MAX_W-1:0] width_mask(input int unsigned w);
    logic [GRAY_MAX_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < GRAY_MAX_W; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b,
                                                      input int unsigned          w);
    logic [GRAY_MAX_W-1:0] bm;
    bm = b & width_mask(w);
    return bm ^ (bm >> 1);
  endfunction

  // Prefix XOR from the MSB down; bits above w are masked to zero so they do
  // not contribute to the running parity.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g,
                                                      input int unsigned          w);
    logic [GRAY_MAX_W-1:0] gm;
    logic [GRAY_MAX_W-1:0] b;
    logic                  acc;
    gm  = g & width_mask(w);
    b   = '0;
    acc = 1'b0;
    for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
      acc  = acc ^ gm[i];
      b[i] = acc;
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [GRAY_MAX_W-1:0] v,
                                           input int unsigned          w);
    logic [GRAY_MAX_W-1:0] vm;
    int unsigned           n;
    vm = v & width_mask(w);
    n  = 0;
    for (int unsigned i = 0; i < GRAY_MAX_W; i++) begin
      n += 32'(vm[i]);
    end
    return n;
  endfunction

endpackage : gray_pkg

// File: rtl/gray_conv.sv
// gray_conv: combinational binary <-> reflected Gray converter.
//
// Parameters:
//   Width - code width in bits (2 .. GRAY_MAX_W)
//   Dir   - ConvBin2Gray: out = in ^ (in >> 1)
//           ConvGray2Bin: out[W-1] = in[W-1]; out[i] = out[i+1] ^ in[i]
//
// Ports:
//   in_i  - input code word
//   out_o - converted code word
module gray_conv
  import gray_pkg::*;
#(
  parameter int unsigned Width = 4,
  parameter conv_dir_e   Dir   = ConvBin2Gray
) (
  input  logic [Width-1:0] in_i,
  output logic [Width-1:0] out_o
);

  if (Dir == ConvBin2Gray) begin : gen_bin2gray
    assign out_o = in_i ^ (in_i >> 1);
  end else begin : gen_gray2bin
    // Running parity from the MSB down avoids reading out_o inside its own
    // always_comb block.
    always_comb begin
      logic acc;
      out_o = '0;
      acc   = 1'b0;
      for (int i = Width - 1; i >= 0; i--) begin
        acc      = acc ^ in_i[i];
        out_o[i] = acc;
      end
    end
  end

endmodule : gray_conv

// File: rtl/gray_counter.sv
// gray_counter: registered up/down counter presenting binary and Gray views.
//
// Counts in binary and derives the Gray code of the next value before the
// register, so bin_o and gray_o always update on the same edge and gray_o is
// glitch-free (suitable as a CDC FIFO pointer).
//
// Parameters:
//   WIDTH   - counter width in bits (2 .. GRAY_MAX_W)
//   RST_VAL - binary value taken on reset
//
// Ports:
//   clk         - rising-edge clock
//   rst         - synchronous active-high reset
//   en_i        - count enable, one step per cycle
//   up_i        - 1 = increment, 0 = decrement
//   load_i      - synchronous load strobe (overrides en_i)
//   load_gray_i - 1 = ld_val_i is Gray-encoded, 0 = binary
//   ld_val_i    - load value
//   bin_o       - registered binary count
//   gray_o      - registered Gray count (bin_o ^ (bin_o >> 1))
//   wrap_o      - one-cycle pulse after a modulo wrap step
//   chg_o       - mask of gray_o bits that changed on the last edge
//   sat_o       - (GRAY_CNT_SATURATE_EN only) enabled step blocked at a bound
//
// Build option:
//   GRAY_CNT_SATURATE_EN - when defined, counting saturates at 0 and
//                          2^WIDTH-1 instead of wrapping, and sat_o exists.
//
// Edge priority: rst > load_i > en_i > hold.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic             load_gray_i,
  input  logic [WIDTH-1:0] ld_val_i,
  output logic [WIDTH-1:0] bin_o,
  output logic [WIDTH-1:0] gray_o,
  output logic             wrap_o,
  output logic [WIDTH-1:0] chg_o
`ifdef GRAY_CNT_SATURATE_EN
  ,
  output logic             sat_o
`endif
);

  localparam logic [WIDTH-1:0] RstBin  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] RstGray = RstBin ^ (RstBin >> 1);
  localparam logic [WIDTH-1:0] One     = WIDTH'(1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] chg_q, chg_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] ld_bin;
  logic             at_max, at_min;
`ifdef GRAY_CNT_SATURATE_EN
  logic             sat_q, sat_d;
`endif

  // Load path: decode a Gray-encoded load value back to binary.
  gray_conv #(
    .Width(WIDTH),
    .Dir  (ConvGray2Bin)
  ) u_ld_conv (
    .in_i (ld_val_i),
    .out_o(ld_bin)
  );

  // Output path: Gray code of the next count, registered with bin_q.
  gray_conv #(
    .Width(WIDTH),
    .Dir  (ConvBin2Gray)
  ) u_out_conv (
    .in_i (bin_d),
    .out_o(gray_d)
  );

  assign at_max = &bin_q;
  assign at_min = ~|bin_q;

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
`ifdef GRAY_CNT_SATURATE_EN
    sat_d  = 1'b0;
`endif
    if (load_i) begin
      bin_d = load_gray_i ? ld_bin : ld_val_i;
    end else if (en_i) begin
      if (up_i) begin
`ifdef GRAY_CNT_SATURATE_EN
        if (at_max) begin
          sat_d = 1'b1;
        end else begin
          bin_d = bin_q + One;
        end
`else
        bin_d  = bin_q + One;
        wrap_d = at_max;
`endif
      end else begin
`ifdef GRAY_CNT_SATURATE_EN
        if (at_min) begin
          sat_d = 1'b1;
        end else begin
          bin_d = bin_q - One;
        end
`else
        bin_d  = bin_q - One;
        wrap_d = at_min;
`endif
      end
    end
  end

  // Hold and saturated steps leave gray unchanged, so the mask is naturally
  // zero there; a count step flips exactly one Gray bit; a load may flip many.
  assign chg_d = gray_q ^ gray_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= RstBin;
      gray_q <= RstGray;
      wrap_q <= 1'b0;
      chg_q  <= '0;
`ifdef GRAY_CNT_SATURATE_EN
      sat_q  <= 1'b0;
`endif
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
      chg_q  <= chg_d;
`ifdef GRAY_CNT_SATURATE_EN
      sat_q  <= sat_d;
`endif
    end
  end

  assign bin_o  = bin_q;
  assign gray_o = gray_q;
  assign wrap_o = wrap_q;
  assign chg_o  = chg_q;
`ifdef GRAY_CNT_SATURATE_EN
  assign sat_o  = sat_q;
`endif

endmodule : gray_counter

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed self-checking bench for gray_counter
// (WIDTH = 4, RST_VAL = 5). Expected values are hand-computed constants.
module tb_gray_counter;
  import gray_pkg::*;

  logic       clk;
  logic       rst;
  logic       en_i;
  logic       up_i;
  logic       load_i;
  logic       load_gray_i;
  logic [3:0] ld_val_i;
  logic [3:0] bin_o;
  logic [3:0] gray_o;
  logic       wrap_o;
  logic [3:0] chg_o;
`ifdef GRAY_CNT_SATURATE_EN
  logic       sat_o;
`endif

  int checks;
  int failures;

  gray_counter #(
    .WIDTH  (4),
    .RST_VAL(5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en_i),
    .up_i       (up_i),
    .load_i     (load_i),
    .load_gray_i(load_gray_i),
    .ld_val_i   (ld_val_i),
    .bin_o      (bin_o),
    .gray_o     (gray_o),
    .wrap_o     (wrap_o),
    .chg_o      (chg_o)
`ifdef GRAY_CNT_SATURATE_EN
    ,
    .sat_o      (sat_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bin(input logic [3:0] v);
    load_i = 1'b1; load_gray_i = 1'b0; ld_val_i = v; en_i = 1'b0;
    step();
    load_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en_i = 1'b1; up_i = 1'b1; load_i = 1'b0;
    step();
    step();
    checks++;
    if (bin_o !== 4'd5) begin
      failures++; $display("FAIL reset_bin: got %h expected %h", bin_o, 4'd5);
    end
    checks++;
    if (gray_o !== 4'b0111) begin
      failures++; $display("FAIL reset_gray: got %h expected %h", gray_o, 4'b0111);
    end
    checks++;
    if (wrap_o !== 1'b0) begin
      failures++; $display("FAIL reset_wrap: got %b expected 0", wrap_o);
    end
    checks++;
    if (chg_o !== 4'b0000) begin
      failures++; $display("FAIL reset_chg: got %h expected 0", chg_o);
    end
    rst = 1'b0; en_i = 1'b0;
  endtask

  task automatic test_load_binary();
    load_bin(4'd0);
    checks++;
    if (bin_o !== 4'd0 || gray_o !== 4'd0) begin
      failures++; $display("FAIL load_bin: got bin=%h gray=%h expected 0/0", bin_o, gray_o);
    end
    // 0111 -> 0000: multi-hot change mask, no wrap
    checks++;
    if (chg_o !== 4'b0111 || wrap_o !== 1'b0) begin
      failures++; $display("FAIL load_chg: got chg=%h wrap=%b expected 7/0", chg_o, wrap_o);
    end
  endtask

`ifndef GRAY_CNT_SATURATE_EN
  task automatic test_up_sweep();
    logic [3:0] exp_g [0:16];
    int         wraps;
    exp_g = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
              4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    wraps = 0;
    en_i = 1'b1; up_i = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      checks++;
      if (gray_o !== exp_g[i] || bin_o !== 4'(i)) begin
        failures++;
        $display("FAIL sweep_val[%0d]: got bin=%h gray=%h expected %h/%h",
                 i, bin_o, gray_o, 4'(i), exp_g[i]);
      end
      checks++;
      if (popcount(32'(chg_o), 4) != 1 || chg_o !== (exp_g[i] ^ exp_g[i-1])) begin
        failures++;
        $display("FAIL sweep_chg[%0d]: got %h expected %h", i, chg_o, exp_g[i] ^ exp_g[i-1]);
      end
      checks++;
      if (wrap_o !== (i == 16)) begin
        failures++; $display("FAIL sweep_wrap[%0d]: got %b expected %b", i, wrap_o, i == 16);
      end
      if (wrap_o === 1'b1) wraps++;
    end
    checks++;
    if (wraps != 1) begin
      failures++; $display("FAIL sweep_wrap_count: got %0d expected 1", wraps);
    end
    en_i = 1'b0;
  endtask

  task automatic test_down_wrap();
    load_bin(4'd0);
    en_i = 1'b1; up_i = 1'b0;
    step();
    en_i = 1'b0;
    checks++;
    if (bin_o !== 4'd15 || gray_o !== 4'b1000) begin
      failures++; $display("FAIL down_wrap_val: got bin=%h gray=%h expected f/8", bin_o, gray_o);
    end
    checks++;
    if (wrap_o !== 1'b1 || chg_o !== 4'b1000) begin
      failures++; $display("FAIL down_wrap_flag: got wrap=%b chg=%h expected 1/8", wrap_o, chg_o);
    end
    step();
    checks++;
    if (wrap_o !== 1'b0 || chg_o !== 4'b0000 || bin_o !== 4'd15) begin
      failures++;
      $display("FAIL down_wrap_hold: got wrap=%b chg=%h bin=%h expected 0/0/f", wrap_o, chg_o, bin_o);
    end
  endtask
`endif

  task automatic test_gray_load();
    load_bin(4'd15);
    // gray(15) = 1000; load Gray 1101 (bin 9) with en_i high: no extra step
    load_i = 1'b1; load_gray_i = 1'b1; ld_val_i = 4'b1101; en_i = 1'b1; up_i = 1'b1;
    step();
    load_i = 1'b0; load_gray_i = 1'b0; en_i = 1'b0;
    checks++;
    if (bin_o !== 4'd9 || gray_o !== 4'b1101) begin
      failures++; $display("FAIL gray_load_val: got bin=%h gray=%h expected 9/d", bin_o, gray_o);
    end
    checks++;
    if (chg_o !== 4'b0101 || wrap_o !== 1'b0) begin
      failures++; $display("FAIL gray_load_chg: got chg=%h wrap=%b expected 5/0", chg_o, wrap_o);
    end
  endtask

  task automatic test_direction_change();
    // From 9: up to 10 (gray f), then immediately down to 9 (gray d)
    en_i = 1'b1; up_i = 1'b1;
    step();
    checks++;
    if (bin_o !== 4'd10 || gray_o !== 4'hF || chg_o !== 4'b0010) begin
      failures++;
      $display("FAIL dir_up: got bin=%h gray=%h chg=%h expected a/f/2", bin_o, gray_o, chg_o);
    end
    up_i = 1'b0;
    step();
    en_i = 1'b0;
    checks++;
    if (bin_o !== 4'd9 || gray_o !== 4'hD || chg_o !== 4'b0010) begin
      failures++;
      $display("FAIL dir_down: got bin=%h gray=%h chg=%h expected 9/d/2", bin_o, gray_o, chg_o);
    end
  endtask

  task automatic test_back_to_back();
    load_bin(4'd3);
    // Gray 0110 decodes to 4; change mask 0010 ^ 0110 = 0100
    load_i = 1'b1; load_gray_i = 1'b1; ld_val_i = 4'b0110;
    step();
    load_i = 1'b0; load_gray_i = 1'b0;
    checks++;
    if (bin_o !== 4'd4 || gray_o !== 4'b0110 || chg_o !== 4'b0100) begin
      failures++;
      $display("FAIL b2b_load: got bin=%h gray=%h chg=%h expected 4/6/4", bin_o, gray_o, chg_o);
    end
  endtask

  task automatic test_collision();
    rst = 1'b1; load_i = 1'b1; load_gray_i = 1'b0; ld_val_i = 4'd7; en_i = 1'b1;
    step();
    rst = 1'b0; load_i = 1'b0; en_i = 1'b0;
    checks++;
    if (bin_o !== 4'd5 || gray_o !== 4'b0111 || chg_o !== 4'b0000 || wrap_o !== 1'b0) begin
      failures++;
      $display("FAIL collision_rst: got bin=%h gray=%h chg=%h wrap=%b expected 5/7/0/0",
               bin_o, gray_o, chg_o, wrap_o);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bin_o !== 4'd5 || gray_o !== 4'b0111 || chg_o !== 4'b0000 || wrap_o !== 1'b0) begin
        failures++;
        $display("FAIL collision_hold[%0d]: got bin=%h gray=%h chg=%h wrap=%b expected 5/7/0/0",
                 i, bin_o, gray_o, chg_o, wrap_o);
      end
    end
  endtask

`ifdef GRAY_CNT_SATURATE_EN
  task automatic test_saturate();
    load_bin(4'd15);
    en_i = 1'b1; up_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bin_o !== 4'd15 || sat_o !== 1'b1 || wrap_o !== 1'b0 || chg_o !== 4'b0000) begin
        failures++;
        $display("FAIL sat_up[%0d]: got bin=%h sat=%b wrap=%b chg=%h expected f/1/0/0",
                 i, bin_o, sat_o, wrap_o, chg_o);
      end
    end
    en_i = 1'b0;
    load_bin(4'd0);
    en_i = 1'b1; up_i = 1'b0;
    step();
    en_i = 1'b0;
    checks++;
    if (bin_o !== 4'd0 || sat_o !== 1'b1 || wrap_o !== 1'b0) begin
      failures++;
      $display("FAIL sat_down: got bin=%h sat=%b wrap=%b expected 0/1/0", bin_o, sat_o, wrap_o);
    end
    step();
    checks++;
    if (sat_o !== 1'b0) begin
      failures++; $display("FAIL sat_clear: got %b expected 0", sat_o);
    end
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; en_i = 1'b0; up_i = 1'b1; load_i = 1'b0; load_gray_i = 1'b0; ld_val_i = '0;
    test_reset();
    test_load_binary();
`ifndef GRAY_CNT_SATURATE_EN
    test_up_sweep();
    test_down_wrap();
`endif
    test_gray_load();
    test_direction_change();
    test_back_to_back();
    test_collision();
`ifdef GRAY_CNT_SATURATE_EN
    test_saturate();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_gray_counter
